// File: rtl/ex_div_if.sv
// ex_div_if: request/response bundle between the EX stage and the iterative divider.
// The EX stage drives the operands and the start/annul controls and receives the
// packed {remainder, quotient} result together with its ready flag.
interface ex_div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div;
    logic [DATA_W-1:0]     data1;
    logic [DATA_W-1:0]     data2;
    logic                  start;
    logic                  annul;
    logic [2*DATA_W-1:0]   result;
    logic                  ready;

    // Pipeline (EX stage) side
    modport master (
        output signed_div,
        output data1,
        output data2,
        output start,
        output annul,
        input  result,
        input  ready
    );

    // Divider side
    modport slave (
        input  signed_div,
        input  data1,
        input  data2,
        input  start,
        input  annul,
        output result,
        output ready
    );
endinterface

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// One quotient bit is produced per clock. Operands are converted to magnitudes
// when accepted, divided unsigned, and the signs are restored on the final step.
// The result is packed as {remainder, quotient} and is held while ready is high.
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic    clk,
    input  logic    rst,
    ex_div_if.slave bus
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    // Two's complement negation; 0x80..0 maps onto itself and is read as 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand, honouring the signedness of the request.
    function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] v,
                                                input logic              is_signed);
        logic [DATA_W-1:0] m;
        if (is_signed && v[DATA_W-1]) begin
            m = f_neg(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Registered state
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_dvd;      // dividend magnitude, consumed MSB first
    logic [DATA_W-1:0]     r_dvs;      // divisor magnitude
    logic [DATA_W-1:0]     r_quot;     // quotient bits collected so far
    logic [DATA_W-1:0]     r_rem;      // partial remainder (always < divisor)
    logic                  r_signed;
    logic                  r_sign1;
    logic                  r_sign2;
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    // Next-state values
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_W-1:0]     w_dvd_nxt;
    logic [DATA_W-1:0]     w_dvs_nxt;
    logic [DATA_W-1:0]     w_quot_nxt;
    logic [DATA_W-1:0]     w_rem_nxt;
    logic                  w_signed_nxt;
    logic                  w_sign1_nxt;
    logic                  w_sign2_nxt;
    logic [2*DATA_W-1:0]   w_result_nxt;
    logic                  w_ready_nxt;

    // Datapath helpers
    logic [DATA_W:0]       w_shift;    // remainder shifted left with next dividend bit
    logic [DATA_W:0]       w_trial;    // trial subtraction of the divisor
    logic [DATA_W-1:0]     w_quot_fix;
    logic [DATA_W-1:0]     w_rem_fix;

    // One restoring step plus the final sign correction of quotient and remainder.
    always_comb begin
        w_shift = {r_rem, r_dvd[DATA_W-1]};
        w_trial = w_shift - {1'b0, r_dvs};
        if (r_signed && (r_sign1 != r_sign2)) begin
            w_quot_fix = f_neg(r_quot);
        end else begin
            w_quot_fix = r_quot;
        end
        if (r_signed && r_sign1) begin
            w_rem_fix = f_neg(r_rem);
        end else begin
            w_rem_fix = r_rem;
        end
    end

    // Next-state and output decode; everything holds unless a state says otherwise.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dvd_nxt    = r_dvd;
        w_dvs_nxt    = r_dvs;
        w_quot_nxt   = r_quot;
        w_rem_nxt    = r_rem;
        w_signed_nxt = r_signed;
        w_sign1_nxt  = r_sign1;
        w_sign2_nxt  = r_sign2;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;

        case (r_state)
            FREE: begin
                w_result_nxt = {(2*DATA_W){1'b0}};
                w_ready_nxt  = 1'b0;
                if (bus.start && !bus.annul) begin
                    w_dvd_nxt    = f_mag(bus.data1, bus.signed_div);
                    w_dvs_nxt    = f_mag(bus.data2, bus.signed_div);
                    w_signed_nxt = bus.signed_div;
                    w_sign1_nxt  = bus.data1[DATA_W-1];
                    w_sign2_nxt  = bus.data2[DATA_W-1];
                    w_quot_nxt   = {DATA_W{1'b0}};
                    w_rem_nxt    = {DATA_W{1'b0}};
                    w_cnt_nxt    = {CNT_W{1'b0}};
                    if (bus.data2 == {DATA_W{1'b0}}) begin
                        w_state_nxt = BY_ZERO;
                    end else begin
                        w_state_nxt = ON;
                    end
                end else begin
                    w_state_nxt = FREE;
                end
            end

            BY_ZERO: begin
                w_result_nxt = {(2*DATA_W){1'b0}};
                if (bus.annul) begin
                    w_state_nxt = FREE;
                    w_ready_nxt = 1'b0;
                end else begin
                    w_state_nxt = END;
                    w_ready_nxt = 1'b1;
                end
            end

            ON: begin
                if (bus.annul) begin
                    // Flush: drop the partial result entirely.
                    w_state_nxt  = FREE;
                    w_result_nxt = {(2*DATA_W){1'b0}};
                    w_ready_nxt  = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    // All quotient bits are in; restore signs and publish.
                    w_state_nxt  = END;
                    w_result_nxt = {w_rem_fix, w_quot_fix};
                    w_ready_nxt  = 1'b1;
                end else begin
                    w_dvd_nxt = {r_dvd[DATA_W-2:0], 1'b0};
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (!w_trial[DATA_W]) begin
                        w_rem_nxt  = w_trial[DATA_W-1:0];
                        w_quot_nxt = {r_quot[DATA_W-2:0], 1'b1};
                    end else begin
                        w_rem_nxt  = w_shift[DATA_W-1:0];
                        w_quot_nxt = {r_quot[DATA_W-2:0], 1'b0};
                    end
                end
            end

            END: begin
                // Hold the result until EX releases start; no retrigger while held.
                if (bus.annul || !bus.start) begin
                    w_state_nxt  = FREE;
                    w_result_nxt = {(2*DATA_W){1'b0}};
                    w_ready_nxt  = 1'b0;
                end else begin
                    w_state_nxt = END;
                    w_ready_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt  = FREE;
                w_result_nxt = {(2*DATA_W){1'b0}};
                w_ready_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= FREE;
            r_cnt    <= {CNT_W{1'b0}};
            r_dvd    <= {DATA_W{1'b0}};
            r_dvs    <= {DATA_W{1'b0}};
            r_quot   <= {DATA_W{1'b0}};
            r_rem    <= {DATA_W{1'b0}};
            r_signed <= 1'b0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_result <= {(2*DATA_W){1'b0}};
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dvd    <= w_dvd_nxt;
            r_dvs    <= w_dvs_nxt;
            r_quot   <= w_quot_nxt;
            r_rem    <= w_rem_nxt;
            r_signed <= w_signed_nxt;
            r_sign1  <= w_sign1_nxt;
            r_sign2  <= w_sign2_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign bus.result = r_result;
    assign bus.ready  = r_ready;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed and randomized checks of ex_div against a plain-arithmetic
// reference model (native 64-bit signed/unsigned division and modulo).
module tb_ex_div;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    ex_div_if #(.DATA_W(32)) bus ();

    ex_div #(.DATA_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expectation and log any miscompare.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sd) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one request, check latency, result, hold behaviour and release.
    task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int hold, input string tag);
        int lat;
        int exp_lat;
        exp_lat = (b == 32'd0) ? 1 : 33;
        bus.signed_div = sd;
        bus.data1      = a;
        bus.data2      = b;
        bus.start      = 1'b1;
        @(posedge clk); #1;                       // E0
        bus.data1      = $urandom;                // must not disturb the operation
        bus.data2      = $urandom;
        bus.signed_div = 1'($urandom_range(0, 1));
        lat = 0;
        while (bus.ready !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_res"}, bus.result, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_rdy"}, 64'(bus.ready), 64'd1);
            check_val({tag, "_hold_res"}, bus.result, exp);
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        check_val({tag, "_rel_rdy"}, 64'(bus.ready), 64'd0);
        check_val({tag, "_rel_res"}, bus.result, 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sd;
        int          seen;
        n_vec = 0;
        n_err = 0;
        rst            = 1'b0;
        bus.signed_div = 1'b0;
        bus.data1      = 32'd0;
        bus.data2      = 32'd0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_rdy", 64'(bus.ready), 64'd0);
        check_val("reset_res", bus.result, 64'd0);
        rst = 1'b1;

        // Directed vectors with hand-computed results
        run_op(1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 10, "divu_100_7");
        run_op(1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 1,  "div_m7_2");
        run_op(1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1,  "div_7_m2");
        run_op(1'b0, 32'h00001234,   32'd0,        64'd0,                 2,  "divu_by0");
        run_op(1'b1, 32'h00001234,   32'd0,        64'd0,                 2,  "div_by0");
        run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 1,  "div_ovf");

        // Annul mid-operation at E0+10
        bus.signed_div = 1'b0;
        bus.data1      = 32'hFFFFFFFF;
        bus.data2      = 32'd3;
        bus.start      = 1'b1;
        @(posedge clk); #1;                       // E0
        seen = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) seen = 1;
        end
        bus.annul = 1'b1;
        @(posedge clk); #1;                       // E0+10
        check_val("annul_rdy", 64'(bus.ready), 64'd0);
        check_val("annul_res", bus.result, 64'd0);
        bus.annul = 1'b0;
        bus.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) seen = 1;
        end
        check_val("annul_no_ready", 64'(seen), 64'd0);
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 0, "annul_next");

        // Reset mid-ON at E0+5, then a fresh operation with start still high
        a = $urandom;
        b = $urandom | 32'd1;
        bus.signed_div = 1'b0;
        bus.data1      = a;
        bus.data2      = b;
        bus.start      = 1'b1;
        @(posedge clk); #1;                       // E0
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;                       // E0+5
        check_val("rst_mid_rdy", 64'(bus.ready), 64'd0);
        check_val("rst_mid_res", bus.result, 64'd0);
        rst = 1'b1;
        run_op(1'b0, a, b, ref_div(1'b0, a, b), 2, "post_reset");

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFFFFFF;
                3:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(sd, a, b, ref_div(sd, a, b), $urandom_range(0, 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
